// File: rtl/efuse_macro_seq_if.sv
// Request/response handshake between the eFuse read/write controller (master)
// and the macro timing sequencer (slave).
interface efuse_macro_seq_if #(
  parameter int NR = 64,
  parameter int NW = 64
) ();
  logic                      read_start;
  logic [$clog2(256/NR)-1:0] read_sel;
  logic                      write_start;
  logic [$clog2(256/NW)-1:0] write_sel;
  logic [NW-1:0]             write_data;
  logic                      read_done;
  logic [NR-1:0]             read_data;
  logic                      efuse_busy_read;
  logic                      write_done;
  logic                      efuse_busy_write;

  modport master (
    output read_start, read_sel, write_start, write_sel, write_data,
    input  read_done, read_data, efuse_busy_read, write_done, efuse_busy_write
  );

  modport slave (
    input  read_start, read_sel, write_start, write_sel, write_data,
    output read_done, read_data, efuse_busy_read, write_done, efuse_busy_write
  );
endinterface

// File: rtl/efuse_macro_seq.sv
// Pin-level timing sequencer for a 32x8 eFuse macro: byte reads, bit-serial programming.
// Optional build macro EFUSE_PGM_SKIP_ZERO_EN: zero bits skip the program window (1 cycle each).
module efuse_macro_seq #(
  parameter int NR    = 64,
  parameter int NW    = 64,
  parameter int T_SU  = 2,
  parameter int T_RD  = 4,
  parameter int T_HD  = 2,
  parameter int T_PGM = 100
) (
  input  logic              clk,
  input  logic              rst,
  efuse_macro_seq_if.slave  ctl,
  output logic              efuse_csb,
  output logic              efuse_load,
  output logic              efuse_pgenb,
  output logic              efuse_strobe,
  output logic [7:0]        efuse_addr,
  input  logic [7:0]        efuse_dout
);

  localparam int NB      = NR / 8;
  localparam int RSEL_W  = $clog2(256 / NR);
  localparam int WSEL_W  = $clog2(256 / NW);
  localparam int T_A     = (T_SU > T_RD) ? T_SU : T_RD;
  localparam int T_B     = (T_HD > T_PGM) ? T_HD : T_PGM;
  localparam int T_MAX   = (T_A > T_B) ? T_A : T_B;
  localparam int PH_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int IDX_MAX = (NB > NW) ? NB : NW;
  localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE, RD_SU, RD_STB, RD_HD, PG_SU, PG_STB, PG_HD, PG_NEXT, DONE
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   ph;
  logic [IDX_W-1:0]  idx;
  logic [RSEL_W-1:0] rsel_q;
  logic [WSEL_W-1:0] wsel_q;
  logic [NW-1:0]     wd_sh;
  logic [NR-1:0]     shadow;
  logic [NR-1:0]     read_data_q;
  logic              read_done_q, write_done_q, busy_rd_q, busy_wr_q;

  logic [IDX_W-1:0]  idx_nxt;
  logic [NW-1:0]     wd_nxt;
  logic              last_byte, last_bit, bit_end;
  logic [WSEL_W-1:0] nb_sel;
  logic [IDX_W-1:0]  nb_idx;
  logic [7:0]        nb_addr;
  state_t            nb_state;
  logic              nb_csb, nb_pgenb;
`ifdef EFUSE_PGM_SKIP_ZERO_EN
  logic              nb_d;
`endif

  function automatic logic [7:0] rd_addr(input logic [RSEL_W-1:0] sel, input logic [IDX_W-1:0] k);
    return 8'((int'(sel) * NB + int'(k)) * 8);
  endfunction

  assign idx_nxt   = idx + 1'b1;
  assign wd_nxt    = wd_sh >> 1;
  assign last_byte = (idx == IDX_W'(NB - 1));
  assign last_bit  = (idx == IDX_W'(NW - 1));
  assign bit_end   = (state == PG_NEXT) || ((state == PG_HD) && (ph == PH_W'(T_HD - 1)));

  // Entry decode for the next program bit, shared by write acceptance and bit completion
  always_comb begin
    nb_sel   = (state == IDLE) ? ctl.write_sel : wsel_q;
    nb_idx   = (state == IDLE) ? '0 : idx_nxt;
    nb_addr  = 8'(int'(nb_sel) * NW + int'(nb_idx));
    nb_state = PG_SU;
    nb_csb   = 1'b0;
    nb_pgenb = 1'b0;
`ifdef EFUSE_PGM_SKIP_ZERO_EN
    nb_d = (state == IDLE) ? ctl.write_data[0] : wd_nxt[0];
    if (!nb_d) begin
      nb_state = PG_NEXT;
      nb_csb   = 1'b1;
      nb_pgenb = 1'b1;
      nb_addr  = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ph           <= '0;
      idx          <= '0;
      rsel_q       <= '0;
      wsel_q       <= '0;
      wd_sh        <= '0;
      shadow       <= '0;
      read_data_q  <= '0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
      busy_rd_q    <= 1'b0;
      busy_wr_q    <= 1'b0;
      efuse_csb    <= 1'b1;
      efuse_load   <= 1'b0;
      efuse_pgenb  <= 1'b1;
      efuse_strobe <= 1'b0;
      efuse_addr   <= '0;
    end else begin
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ctl.read_start) begin
            rsel_q     <= ctl.read_sel;
            idx        <= '0;
            ph         <= '0;
            busy_rd_q  <= 1'b1;
            state      <= RD_SU;
            efuse_csb  <= 1'b0;
            efuse_load <= 1'b1;
            efuse_addr <= rd_addr(ctl.read_sel, '0);
          end else if (ctl.write_start) begin
            wsel_q      <= ctl.write_sel;
            wd_sh       <= ctl.write_data;
            busy_wr_q   <= 1'b1;
            idx         <= nb_idx;
            ph          <= '0;
            state       <= nb_state;
            efuse_csb   <= nb_csb;
            efuse_pgenb <= nb_pgenb;
            efuse_addr  <= nb_addr;
          end
        end
        RD_SU: begin
          if (ph == PH_W'(T_SU - 1)) begin
            ph           <= '0;
            state        <= RD_STB;
            efuse_strobe <= 1'b1;
          end else ph <= ph + 1'b1;
        end
        RD_STB: begin
          if (ph == PH_W'(T_RD - 1)) begin
            ph           <= '0;
            state        <= RD_HD;
            efuse_strobe <= 1'b0;
            // Bytes shift in from the top so byte k lands at [8k+7:8k] after NB captures
            shadow       <= NR'({efuse_dout, shadow} >> 8);
          end else ph <= ph + 1'b1;
        end
        RD_HD: begin
          if (ph == PH_W'(T_HD - 1)) begin
            ph <= '0;
            if (last_byte) begin
              state       <= DONE;
              read_done_q <= 1'b1;
              read_data_q <= shadow;
              efuse_csb   <= 1'b1;
              efuse_load  <= 1'b0;
              efuse_addr  <= '0;
            end else begin
              idx        <= idx_nxt;
              state      <= RD_SU;
              efuse_addr <= rd_addr(rsel_q, idx_nxt);
            end
          end else ph <= ph + 1'b1;
        end
        PG_SU: begin
          if (ph == PH_W'(T_SU - 1)) begin
            ph           <= '0;
            state        <= PG_STB;
            efuse_strobe <= wd_sh[0];
          end else ph <= ph + 1'b1;
        end
        PG_STB: begin
          if (ph == PH_W'(T_PGM - 1)) begin
            ph           <= '0;
            state        <= PG_HD;
            efuse_strobe <= 1'b0;
          end else ph <= ph + 1'b1;
        end
        PG_HD: begin
          if (!bit_end) ph <= ph + 1'b1;
        end
        PG_NEXT: ;
        DONE: begin
          state     <= IDLE;
          busy_rd_q <= 1'b0;
          busy_wr_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (bit_end) begin
        ph <= '0;
        if (last_bit) begin
          state        <= DONE;
          write_done_q <= 1'b1;
          efuse_csb    <= 1'b1;
          efuse_pgenb  <= 1'b1;
          efuse_addr   <= '0;
        end else begin
          wd_sh       <= wd_nxt;
          idx         <= nb_idx;
          state       <= nb_state;
          efuse_csb   <= nb_csb;
          efuse_pgenb <= nb_pgenb;
          efuse_addr  <= nb_addr;
        end
      end
    end
  end

  assign ctl.read_done        = read_done_q;
  assign ctl.read_data        = read_data_q;
  assign ctl.efuse_busy_read  = busy_rd_q;
  assign ctl.write_done       = write_done_q;
  assign ctl.efuse_busy_write = busy_wr_q;

endmodule

// File: doc/efuse_macro_seq.md
Name: efuse_macro_seq

Overview:
- Timing sequencer directly downstream of the eFuse read/write controller; it consumes the controller's read_start/write_start requests.
- Drives the pins of a 256-bit eFuse macro organised as 32x8: chip select, load, program enable, strobe, address and 8-bit data out.
- Reads NR bits as NR/8 byte accesses and programs NW bits one bit at a time.
- Returns read_done/read_data, write_done and per-direction busy flags.

Parameters:
- NR, 64: read chunk width in bits; multiple of 8; divides 256.
- NW, 64: write chunk width in bits; divides 256.
- T_SU, 2: setup cycles (address and mode stable before strobe); >=1.
- T_RD, 4: read strobe high cycles; >=1.
- T_HD, 2: hold cycles after strobe falls; >=1.
- T_PGM, 100: program strobe high cycles; >=1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- read_start  in  1  read request pulse.
- read_sel  in  $clog2(256/NR)  read chunk index.
- write_start  in  1  program request pulse.
- write_sel  in  $clog2(256/NW)  write chunk index.
- write_data  in  NW  bits to program; 1 = blow.
- read_done  out  1  one-cycle pulse, read complete.
- read_data  out  NR  last read chunk; held until the next read_done.
- efuse_busy_read  out  1  read in progress.
- write_done  out  1  one-cycle pulse, program complete.
- efuse_busy_write  out  1  program in progress.
- efuse_csb  out  1  macro chip select, active low.
- efuse_load  out  1  macro read mode.
- efuse_pgenb  out  1  macro program enable, active low.
- efuse_strobe  out  1  macro strobe.
- efuse_addr  out  8  read: {byte[4:0],3'b000}; program: {byte[4:0],bit[2:0]}.
- efuse_dout  in  8  macro read data.

Behaviour:
- Reset values: read_data=0; all done/busy = 0; efuse_csb=1, efuse_pgenb=1, efuse_load=0, efuse_strobe=0, efuse_addr=0 (the safe pin state).
- All outputs are registered.
- FSM states: IDLE, RD_SU, RD_STB, RD_HD, PG_SU, PG_STB, PG_HD, PG_NEXT, DONE.
- Start acceptance, IDLE only:
  - read_start has priority; a write_start in the same cycle is dropped.
  - Starts arriving in any other state are ignored.
  - read_sel, write_sel and write_data are latched on acceptance.
- Busy: the matching busy goes high the cycle after acceptance and stays high through the done-pulse cycle inclusive.
- Read sequence:
  - NB = NR/8 bytes, byte index b = read_sel*NB + k, for k = 0..NB-1.
  - RD_SU, T_SU cycles: csb=0, load=1, pgenb=1, addr set, strobe=0.
  - RD_STB, T_RD cycles: strobe=1.
  - efuse_dout is sampled on the edge ending the last RD_STB cycle into shadow bits [8k+7:8k].
  - RD_HD, T_HD cycles: strobe=0, address held.
  - Then the next byte, or DONE.
- Write sequence, for bit i = 0..NW-1:
  - Global bit g = write_sel*NW + i; addr = g.
  - PG_SU, T_SU cycles: csb=0, pgenb=0, load=0.
  - PG_STB, T_PGM cycles: strobe = write_data[i].
  - PG_HD, T_HD cycles: strobe=0.
  - Then PG_NEXT (0 cycles without the optional feature; see below), next bit or DONE.
- DONE, one cycle:
  - For a read: read_done=1 and read_data <= shadow, same edge.
  - For a write: write_done=1.
  - Pins return to the safe state; next state is IDLE.
- Read latency: read_done is high exactly 1+NB*(T_SU+T_RD+T_HD) cycles after the read_start cycle.
- Write latency without the optional feature: 1+NW*(T_SU+T_PGM+T_HD).
- Counters:
  - The phase counter is sized for max(T_SU,T_RD,T_HD,T_PGM).
  - The byte/bit index is sized for the maximum index.
  - No wrap beyond the last index; the last index goes to DONE.
- Reset mid-operation: pins go to the safe state immediately (asynchronous); no done pulse; read_data is cleared.
- The strobe is never high while csb=1.
- efuse_load and ~efuse_pgenb are never high in the same cycle.

Optional Feature:
- Macro: EFUSE_PGM_SKIP_ZERO_EN.
- Defined: in PG_NEXT, bits with write_data[i]=0 are skipped.
  - Each skipped bit costs exactly 1 cycle in PG_NEXT, with pins in the safe state.
  - Only 1-bits run PG_SU/PG_STB/PG_HD.
  - Latency = 1 + ones*(T_SU+T_PGM+T_HD) + zeros.
- Undefined: every bit runs the full window with strobe gated by the data bit. Program time is constant.

Test Plan:
- Macro model with byte b = b+0x10, defaults, read_sel=1 -> read_done exactly 65 cycles after start; read_data=64'h1F1E1D1C1B1A1918; efuse_addr steps 0x40,0x48..0x78.
- write_sel=2, write_data=64'h1, macro undefined -> exactly one strobe (100 cycles) at addr 0x80; write_done at cycle 6657; busy_write high cycles 1..6657.
- Same stimulus, macro defined -> write_done at cycle 168. write_data=0 -> write_done at cycle 65, no strobe.
- read_start and write_start in the same cycle -> read executes, no program pins toggle, write_done never pulses. write_start during a read -> ignored.
- rst asserted at cycle 50 of PG_STB -> csb=1, pgenb=1, strobe=0 immediately; no write_done; the next read after release works normally.
- Assertion over all tests: strobe implies ~csb; never load & ~pgenb; exactly one done pulse per accepted start.
